// File: rtl/ddr_rw_arbiter_if.sv
// ddr_rw_arbiter_if
//  Burst handshake between the DDR read/write arbiter and the two AXI burst
//  engines (write master and read master).
//  Signals:
//   axi_wr_start  one-cycle pulse that launches a write burst
//   axi_wr_addr   write burst byte address (30 bits)
//   axi_wr_len    write burst AXI LEN (beats = LEN+1)
//   axi_wr_done   write burst complete (B response accepted)
//   axi_rd_start  one-cycle pulse that launches a read burst
//   axi_rd_addr   read burst byte address (30 bits)
//   axi_rd_len    read burst AXI LEN (beats = LEN+1)
//   axi_rd_done   read burst complete (last R beat accepted)
//  Modports: master = arbiter side, slave = AXI engine side.
interface ddr_rw_arbiter_if;
  logic        axi_wr_start;
  logic [29:0] axi_wr_addr;
  logic [7:0]  axi_wr_len;
  logic        axi_wr_done;
  logic        axi_rd_start;
  logic [29:0] axi_rd_addr;
  logic [7:0]  axi_rd_len;
  logic        axi_rd_done;

  modport master (
    output axi_wr_start, axi_wr_addr, axi_wr_len,
    input  axi_wr_done,
    output axi_rd_start, axi_rd_addr, axi_rd_len,
    input  axi_rd_done
  );

  modport slave (
    input  axi_wr_start, axi_wr_addr, axi_wr_len,
    output axi_wr_done,
    input  axi_rd_start, axi_rd_addr, axi_rd_len,
    output axi_rd_done
  );
endinterface

// File: rtl/ddr_rw_arbiter.sv
// ddr_rw_arbiter
//  Schedules DDR3 bursts between the write path (write FIFO -> AXI write
//  master) and the read path (AXI read master -> read FIFO). One burst is
//  outstanding at a time; when both paths are ready the grant alternates.
//  Each direction walks a wrapping address window [beg_addr, end_addr].
//  Ports:
//   clk, rst_n          controller clock, asynchronous active-low reset
//   calib_done          DDR3 calibration complete
//   wr_/rd_beg_addr     region start byte address
//   wr_/rd_end_addr     region last valid byte address
//   wr_/rd_burst_len    AXI LEN for the next burst
//   rd_mem_enable       allows the read path to request
//   wr_fifo_cnt         beats available in the write FIFO
//   rd_fifo_cnt         beats stored in the read FIFO
//   axi                 burst handshake (master modport)
//   wr_busy, rd_busy    a burst of that direction is outstanding
module ddr_rw_arbiter #(
  parameter int AXI_DATA_W    = 64,
  parameter int FIFO_CNT_W    = 10,
  parameter int RD_FIFO_DEPTH = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  calib_done,
  input  logic [29:0]           wr_beg_addr,
  input  logic [29:0]           wr_end_addr,
  input  logic [7:0]            wr_burst_len,
  input  logic [29:0]           rd_beg_addr,
  input  logic [29:0]           rd_end_addr,
  input  logic [7:0]            rd_burst_len,
  input  logic                  rd_mem_enable,
  input  logic [FIFO_CNT_W-1:0] wr_fifo_cnt,
  input  logic [FIFO_CNT_W-1:0] rd_fifo_cnt,
  ddr_rw_arbiter_if.master      axi,
  output logic                  wr_busy,
  output logic                  rd_busy
);

  localparam int   BYTES    = AXI_DATA_W / 8;
  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;

  state_t      state_reg, state_next;
  logic        last_grant_reg;
  logic [29:0] wr_ptr_reg, rd_ptr_reg;
  logic [29:0] wr_addr_reg, rd_addr_reg;
  logic [7:0]  wr_len_reg, rd_len_reg;
  // Window bounds captured at grant so mid-burst config edits cannot
  // disturb the pointer advance of the outstanding burst.
  logic [29:0] wr_beg_reg, wr_end_reg, rd_beg_reg, rd_end_reg;
  logic        wr_busy_reg, rd_busy_reg;
  logic        wr_start, rd_start;
  logic        wr_req, rd_req, grant_wr, grant_rd;
  logic        wr_finish, rd_finish;

  // Advance by one burst; wrap to beg when the following burst would
  // run past the last valid byte.
  function automatic logic [29:0] next_ptr(input logic [29:0] p,
                                           input logic [7:0]  len,
                                           input logic [29:0] beg,
                                           input logic [29:0] last);
    logic [29:0] step;
    step = (30'(len) + 30'd1) * 30'(BYTES);
    if (p + (step << 1) - 30'd1 > last) next_ptr = beg;
    else                                next_ptr = p + step;
  endfunction

  // Read room is checked as cnt+beats <= depth to avoid a negative free count.
  assign wr_req = calib_done &&
                  (32'(wr_fifo_cnt) >= 32'(wr_burst_len) + 32'd1);
  assign rd_req = calib_done && rd_mem_enable &&
                  (32'(rd_fifo_cnt) + 32'(rd_burst_len) + 32'd1 <= 32'(RD_FIFO_DEPTH));

  assign grant_wr = (state_reg == IDLE) && wr_req && (!rd_req || last_grant_reg == GRANT_RD);
  assign grant_rd = (state_reg == IDLE) && rd_req && (!wr_req || last_grant_reg == GRANT_WR);

  assign wr_finish = (state_reg == WR_WAIT) && axi.axi_wr_done;
  assign rd_finish = (state_reg == RD_WAIT) && axi.axi_rd_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    wr_start   = 1'b0;
    rd_start   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_wr)      state_next = WR_REQ;
        else if (grant_rd) state_next = RD_REQ;
      end
      WR_REQ: begin
        wr_start   = 1'b1;
        state_next = WR_WAIT;
      end
      WR_WAIT: if (axi.axi_wr_done) state_next = IDLE;
      RD_REQ: begin
        rd_start   = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: if (axi.axi_rd_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= GRANT_RD;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      wr_addr_reg    <= '0;
      rd_addr_reg    <= '0;
      wr_len_reg     <= '0;
      rd_len_reg     <= '0;
      wr_beg_reg     <= '0;
      wr_end_reg     <= '0;
      rd_beg_reg     <= '0;
      rd_end_reg     <= '0;
      wr_busy_reg    <= 1'b0;
      rd_busy_reg    <= 1'b0;
    end else begin
      if (grant_wr) begin
        wr_addr_reg    <= wr_ptr_reg;
        wr_len_reg     <= wr_burst_len;
        wr_beg_reg     <= wr_beg_addr;
        wr_end_reg     <= wr_end_addr;
        wr_busy_reg    <= 1'b1;
        last_grant_reg <= GRANT_WR;
      end else if (grant_rd) begin
        rd_addr_reg    <= rd_ptr_reg;
        rd_len_reg     <= rd_burst_len;
        rd_beg_reg     <= rd_beg_addr;
        rd_end_reg     <= rd_end_addr;
        rd_busy_reg    <= 1'b1;
        last_grant_reg <= GRANT_RD;
      end

      if (wr_finish) wr_busy_reg <= 1'b0;
      if (rd_finish) rd_busy_reg <= 1'b0;

      // Reload beats advance: an uncalibrated (or disabled) path restarts
      // from the top of its window.
      if (!calib_done)    wr_ptr_reg <= wr_beg_addr;
      else if (wr_finish) wr_ptr_reg <= next_ptr(wr_ptr_reg, wr_len_reg, wr_beg_reg, wr_end_reg);

      if (!calib_done || !rd_mem_enable) rd_ptr_reg <= rd_beg_addr;
      else if (rd_finish) rd_ptr_reg <= next_ptr(rd_ptr_reg, rd_len_reg, rd_beg_reg, rd_end_reg);
    end
  end

  assign axi.axi_wr_start = wr_start;
  assign axi.axi_wr_addr  = wr_addr_reg;
  assign axi.axi_wr_len   = wr_len_reg;
  assign axi.axi_rd_start = rd_start;
  assign axi.axi_rd_addr  = rd_addr_reg;
  assign axi.axi_rd_len   = rd_len_reg;
  assign wr_busy          = wr_busy_reg;
  assign rd_busy          = rd_busy_reg;

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// tb_ddr_rw_arbiter
//  Directed bench for ddr_rw_arbiter: reset/calibration hold, write address
//  wrap, fair alternation, read enable gating, read FIFO room boundary and
//  reset during an outstanding burst.
module tb_ddr_rw_arbiter;

  logic        clk;
  logic        rst_n;
  logic        calib_done;
  logic [29:0] wr_beg_addr, wr_end_addr, rd_beg_addr, rd_end_addr;
  logic [7:0]  wr_burst_len, rd_burst_len;
  logic        rd_mem_enable;
  logic [9:0]  wr_fifo_cnt, rd_fifo_cnt;
  logic        wr_busy, rd_busy;

  ddr_rw_arbiter_if axi_if();

  ddr_rw_arbiter #(
    .AXI_DATA_W   (64),
    .FIFO_CNT_W   (10),
    .RD_FIFO_DEPTH(512)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .calib_done   (calib_done),
    .wr_beg_addr  (wr_beg_addr),
    .wr_end_addr  (wr_end_addr),
    .wr_burst_len (wr_burst_len),
    .rd_beg_addr  (rd_beg_addr),
    .rd_end_addr  (rd_end_addr),
    .rd_burst_len (rd_burst_len),
    .rd_mem_enable(rd_mem_enable),
    .wr_fifo_cnt  (wr_fifo_cnt),
    .rd_fifo_cnt  (rd_fifo_cnt),
    .axi          (axi_if),
    .wr_busy      (wr_busy),
    .rd_busy      (rd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wr_starts = 0;
  int rd_starts = 0;
  int both_busy = 0;

  always @(negedge clk) begin
    if (axi_if.axi_wr_start) wr_starts++;
    if (axi_if.axi_rd_start) rd_starts++;
    if (wr_busy && rd_busy)  both_busy++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waits for a start pulse (expected one cycle after the enabling negedge),
  // checks address/len/busy, then returns done five cycles after start.
  task automatic do_burst(input bit is_wr, input logic [29:0] exp_addr, input logic [7:0] exp_len);
    int cyc;
    logic st;
    cyc = 0;
    st  = is_wr ? axi_if.axi_wr_start : axi_if.axi_rd_start;
    while (!st && cyc < 50) begin
      @(negedge clk);
      cyc++;
      st = is_wr ? axi_if.axi_wr_start : axi_if.axi_rd_start;
    end
    check(is_wr ? "wr_start" : "rd_start", 32'(st), 32'd1);
    check(is_wr ? "wr_latency" : "rd_latency", 32'(cyc), 32'd1);
    check(is_wr ? "wr_addr" : "rd_addr",
          32'(is_wr ? axi_if.axi_wr_addr : axi_if.axi_rd_addr), 32'(exp_addr));
    check(is_wr ? "wr_len" : "rd_len",
          32'(is_wr ? axi_if.axi_wr_len : axi_if.axi_rd_len), 32'(exp_len));
    $display("burst %s addr=%0d len=%0d", is_wr ? "W" : "R",
             is_wr ? axi_if.axi_wr_addr : axi_if.axi_rd_addr,
             is_wr ? axi_if.axi_wr_len : axi_if.axi_rd_len);
    @(negedge clk);
    check(is_wr ? "wr_pulse_end" : "rd_pulse_end",
          32'(is_wr ? axi_if.axi_wr_start : axi_if.axi_rd_start), 32'd0);
    check(is_wr ? "wr_busy_set" : "rd_busy_set", 32'(is_wr ? wr_busy : rd_busy), 32'd1);
    check(is_wr ? "rd_busy_idle" : "wr_busy_idle", 32'(is_wr ? rd_busy : wr_busy), 32'd0);
    repeat (4) @(negedge clk);
    if (is_wr) axi_if.axi_wr_done = 1'b1; else axi_if.axi_rd_done = 1'b1;
    @(negedge clk);
    axi_if.axi_wr_done = 1'b0;
    axi_if.axi_rd_done = 1'b0;
    check(is_wr ? "wr_busy_clr" : "rd_busy_clr", 32'(is_wr ? wr_busy : rd_busy), 32'd0);
  endtask

  int snap_w, snap_r;

  initial begin
    rst_n              = 1'b0;
    calib_done         = 1'b0;
    wr_beg_addr        = 30'd0;
    wr_end_addr        = 30'd47;
    wr_burst_len       = 8'd1;
    rd_beg_addr        = 30'd1024;
    rd_end_addr        = 30'd1151;
    rd_burst_len       = 8'd3;
    rd_mem_enable      = 1'b1;
    wr_fifo_cnt        = 10'd1023;
    rd_fifo_cnt        = 10'd0;
    axi_if.axi_wr_done = 1'b0;
    axi_if.axi_rd_done = 1'b0;

    // 1: reset hold, then calibration hold with both paths ready
    repeat (3) @(negedge clk);
    check("rst_wr_start", 32'(axi_if.axi_wr_start), 32'd0);
    check("rst_rd_start", 32'(axi_if.axi_rd_start), 32'd0);
    check("rst_wr_addr", 32'(axi_if.axi_wr_addr), 32'd0);
    check("rst_rd_addr", 32'(axi_if.axi_rd_addr), 32'd0);
    check("rst_wr_len", 32'(axi_if.axi_wr_len), 32'd0);
    check("rst_rd_len", 32'(axi_if.axi_rd_len), 32'd0);
    check("rst_busy", {30'd0, wr_busy, rd_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("calib_wr_starts", 32'(wr_starts), 32'd0);
    check("calib_rd_starts", 32'(rd_starts), 32'd0);
    check("calib_wr_ptr", 32'(dut.wr_ptr_reg), 32'd0);
    check("calib_rd_ptr", 32'(dut.rd_ptr_reg), 32'd1024);

    // 2: write-only, step 16, window 0..47 wraps after 32
    rd_mem_enable = 1'b0;
    wr_fifo_cnt   = 10'd2;
    calib_done    = 1'b1;
    do_burst(1'b1, 30'd0, 8'd1);
    do_burst(1'b1, 30'd16, 8'd1);
    do_burst(1'b1, 30'd32, 8'd1);
    do_burst(1'b1, 30'd0, 8'd1);
    do_burst(1'b1, 30'd16, 8'd1);

    // 6: reset during WR_WAIT, then a stray done
    @(negedge clk);
    check("t6_start", 32'(axi_if.axi_wr_start), 32'd1);
    check("t6_addr", 32'(axi_if.axi_wr_addr), 32'd32);
    @(negedge clk);
    check("t6_busy_pre", 32'(wr_busy), 32'd1);
    rst_n       = 1'b0;
    calib_done  = 1'b0;
    wr_fifo_cnt = 10'd0;
    #1;
    check("t6_busy_rst", 32'(wr_busy), 32'd0);
    check("t6_addr_rst", 32'(axi_if.axi_wr_addr), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    snap_w = wr_starts;
    @(negedge clk);
    axi_if.axi_wr_done = 1'b1;
    @(negedge clk);
    axi_if.axi_wr_done = 1'b0;
    @(negedge clk);
    check("t6_busy_after", 32'(wr_busy), 32'd0);
    check("t6_state_idle", 32'(dut.state_reg), 32'd0);
    check("t6_no_start", 32'(wr_starts - snap_w), 32'd0);

    // 3: both requesting -> W,R,W,R starting with W
    wr_fifo_cnt   = 10'd2;
    rd_fifo_cnt   = 10'd0;
    rd_mem_enable = 1'b1;
    calib_done    = 1'b1;
    do_burst(1'b1, 30'd0, 8'd1);
    do_burst(1'b0, 30'd1024, 8'd3);
    do_burst(1'b1, 30'd16, 8'd1);
    do_burst(1'b0, 30'd1056, 8'd3);

    // 4: read disabled -> nothing; enable -> read from rd_beg_addr
    wr_fifo_cnt   = 10'd0;
    rd_mem_enable = 1'b0;
    snap_r        = rd_starts;
    snap_w        = wr_starts;
    repeat (10) @(negedge clk);
    check("t4_no_rd", 32'(rd_starts - snap_r), 32'd0);
    check("t4_no_wr", 32'(wr_starts - snap_w), 32'd0);
    rd_mem_enable = 1'b1;
    do_burst(1'b0, 30'd1024, 8'd3);

    // 5: read FIFO room boundary with LEN=1 (two beats)
    rd_fifo_cnt  = 10'd511;
    rd_burst_len = 8'd1;
    snap_r       = rd_starts;
    repeat (10) @(negedge clk);
    check("t5_full_no_rd", 32'(rd_starts - snap_r), 32'd0);
    rd_fifo_cnt = 10'd510;
    do_burst(1'b0, 30'd1056, 8'd1);

    check("never_both_busy", 32'(both_busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
